// File: rtl/segre_main_memory.sv
// Line-granular main-memory responder: serves one DC or IC line request at a time
// after a fixed latency and answers with a one-cycle ready pulse.
module segre_main_memory #(
    parameter int ADDR_SIZE = 32,
    parameter int LANE_SIZE = 128,
    parameter int MEM_LINES = 1024,
    parameter int LATENCY   = 4
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 dc_req_i,
    input  logic                 dc_wr_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    input  logic [LANE_SIZE-1:0] dc_data_i,
    output logic                 dc_rdy_o,
    output logic [LANE_SIZE-1:0] dc_data_o,
    input  logic                 ic_req_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_rdy_o,
    output logic [LANE_SIZE-1:0] ic_data_o,
    output logic                 busy_o
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 accept_dc, accept_ic, fire;
    logic                 src_dc, wr_q;
    logic [IDX_W-1:0]     idx_q;
    logic [LANE_SIZE-1:0] line_q;
    logic [LANE_SIZE-1:0] mem [MEM_LINES];

    // Byte offset and aliasing upper address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dc_addr_i[3:0], dc_addr_i[ADDR_SIZE-1:IDX_W+4],
                                ic_addr_i[3:0], ic_addr_i[ADDR_SIZE-1:IDX_W+4]};

    always_ff @(posedge clk_i) begin
        if (!rsn_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept_dc = 1'b0;
        accept_ic = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (dc_req_i) begin
                    accept_dc = 1'b1;
                    state_nxt = BUSY;
                end else if (ic_req_i) begin
                    accept_ic = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    fire      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rsn_i)                          cnt <= '0;
        else if (accept_dc || accept_ic)     cnt <= CNT_W'(LATENCY - 1);
        else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
    end

    // Request fields are captured once so later input changes cannot disturb the transaction.
    always_ff @(posedge clk_i) begin
        if (accept_dc) begin
            src_dc <= 1'b1;
            wr_q   <= dc_wr_i;
            idx_q  <= dc_addr_i[IDX_W+3:4];
            line_q <= dc_data_i;
        end else if (accept_ic) begin
            src_dc <= 1'b0;
            wr_q   <= 1'b0;
            idx_q  <= ic_addr_i[IDX_W+3:4];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rsn_i && fire && src_dc && wr_q) mem[idx_q] <= line_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            dc_rdy_o  <= 1'b0;
            ic_rdy_o  <= 1'b0;
            dc_data_o <= '0;
            ic_data_o <= '0;
        end else begin
            dc_rdy_o <= fire && src_dc;
            ic_rdy_o <= fire && !src_dc;
            if (fire && src_dc)  dc_data_o <= wr_q ? line_q : mem[idx_q];
            if (fire && !src_dc) ic_data_o <= mem[idx_q];
        end
    end

endmodule

// File: tb/tb_segre_main_memory.sv
// Directed bench for segre_main_memory: default LATENCY=4 instance plus a LATENCY=1 instance.
module tb_segre_main_memory;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] D3 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] D4 = 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;
    localparam logic [127:0] D5 = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

    logic         clk = 1'b0;
    logic         rsn;
    logic         dc_req, dc_wr, dc_rdy, ic_req, ic_rdy, busy;
    logic [31:0]  dc_addr, ic_addr;
    logic [127:0] dc_wdata, dc_rdata, ic_rdata;

    logic         dc1_req, dc1_wr, dc1_rdy, ic1_req, ic1_rdy, busy1;
    logic [31:0]  dc1_addr, ic1_addr;
    logic [127:0] dc1_wdata, dc1_rdata, ic1_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    segre_main_memory u_dut (
        .clk_i(clk), .rsn_i(rsn),
        .dc_req_i(dc_req), .dc_wr_i(dc_wr), .dc_addr_i(dc_addr), .dc_data_i(dc_wdata),
        .dc_rdy_o(dc_rdy), .dc_data_o(dc_rdata),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_rdy_o(ic_rdy), .ic_data_o(ic_rdata),
        .busy_o(busy)
    );

    segre_main_memory #(.LATENCY(1)) u_dut1 (
        .clk_i(clk), .rsn_i(rsn),
        .dc_req_i(dc1_req), .dc_wr_i(dc1_wr), .dc_addr_i(dc1_addr), .dc_data_i(dc1_wdata),
        .dc_rdy_o(dc1_rdy), .dc_data_o(dc1_rdata),
        .ic_req_i(ic1_req), .ic_addr_i(ic1_addr), .ic_rdy_o(ic1_rdy), .ic_data_o(ic1_rdata),
        .busy_o(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a DC request, wait (bounded) for its pulse, drop it and step one more cycle.
    task automatic do_dc(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                         output int cyc, output logic rdy_after);
        dc_req = 1'b1; dc_wr = wr; dc_addr = addr; dc_wdata = data;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (dc_rdy !== 1'b1 && cyc < 20);
        dc_req = 1'b0;
        tick();
        rdy_after = dc_rdy;
    endtask

    task automatic do_ic(input logic [31:0] addr, output int cyc, output logic rdy_after,
                         output logic dc_seen);
        ic_req = 1'b1; ic_addr = addr;
        cyc = 0;
        dc_seen = 1'b0;
        do begin
            tick();
            cyc++;
            if (dc_rdy === 1'b1) dc_seen = 1'b1;
        end while (ic_rdy !== 1'b1 && cyc < 20);
        ic_req = 1'b0;
        tick();
        rdy_after = ic_rdy;
    endtask

    task automatic do_dc1(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                          output int cyc);
        dc1_req = 1'b1; dc1_wr = wr; dc1_addr = addr; dc1_wdata = data;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (dc1_rdy !== 1'b1 && cyc < 20);
        dc1_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int cyc;
        rsn = 1'b0;
        dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 32'h0000_0120;
        repeat (3) tick();
        total++; if (dc_rdy !== 1'b0) begin bad++; $display("FAIL reset_dc_rdy got=%b want=0", dc_rdy); end
        total++; if (ic_rdy !== 1'b0) begin bad++; $display("FAIL reset_ic_rdy got=%b want=0", ic_rdy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (dc_rdata !== 128'h0) begin bad++; $display("FAIL reset_dc_data got=%h want=0", dc_rdata); end
        total++; if (ic_rdata !== 128'h0) begin bad++; $display("FAIL reset_ic_data got=%h want=0", ic_rdata); end
        total++; if (busy1 !== 1'b0 || dc1_rdy !== 1'b0) begin bad++; $display("FAIL reset_lat1 busy=%b rdy=%b want=0,0", busy1, dc1_rdy); end
        rsn = 1'b1;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_accept_busy got=%b want=1", busy); end
        cyc = 1;
        while (dc_rdy !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        dc_req = 1'b0;
        total++; if (cyc != 5) begin bad++; $display("FAIL reset_first_latency got=%0d want=5", cyc); end
        tick();
        total++; if (dc_rdy !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_pulse_end rdy=%b busy=%b want=0,0", dc_rdy, busy); end
    endtask

    task automatic test_dc_write_read();
        int cyc; logic ra;
        do_dc(1'b1, 32'h0000_0120, D1, cyc, ra);
        total++; if (cyc != 5) begin bad++; $display("FAIL wr_latency got=%0d want=5", cyc); end
        total++; if (ra !== 1'b0) begin bad++; $display("FAIL wr_single_pulse got=%b want=0", ra); end
        total++; if (dc_rdata !== D1) begin bad++; $display("FAIL wr_echo got=%h want=%h", dc_rdata, D1); end
        do_dc(1'b1, 32'h0000_0130, D2, cyc, ra);
        total++; if (dc_rdata !== D2) begin bad++; $display("FAIL wr2_echo got=%h want=%h", dc_rdata, D2); end
        do_dc(1'b0, 32'h0000_012C, 128'h0, cyc, ra);
        total++; if (cyc != 5) begin bad++; $display("FAIL rd_latency got=%0d want=5", cyc); end
        total++; if (ra !== 1'b0) begin bad++; $display("FAIL rd_single_pulse got=%b want=0", ra); end
        total++; if (dc_rdata !== D1) begin bad++; $display("FAIL rd_data got=%h want=%h", dc_rdata, D1); end
        tick();
        total++; if (dc_rdata !== D1) begin bad++; $display("FAIL rd_data_hold got=%h want=%h", dc_rdata, D1); end
    endtask

    task automatic test_ic_fill();
        int cyc; logic ra, dseen;
        do_dc(1'b1, 32'h0000_0400, D3, cyc, ra);
        do_ic(32'h0000_0400, cyc, ra, dseen);
        total++; if (cyc != 5) begin bad++; $display("FAIL ic_latency got=%0d want=5", cyc); end
        total++; if (ra !== 1'b0) begin bad++; $display("FAIL ic_single_pulse got=%b want=0", ra); end
        total++; if (ic_rdata !== D3) begin bad++; $display("FAIL ic_data got=%h want=%h", ic_rdata, D3); end
        total++; if (dseen !== 1'b0) begin bad++; $display("FAIL ic_no_dc_rdy got=%b want=0", dseen); end
        do_ic(32'h0000_4130, cyc, ra, dseen);
        total++; if (ic_rdata !== D2) begin bad++; $display("FAIL ic_alias got=%h want=%h", ic_rdata, D2); end
    endtask

    task automatic test_contention();
        int dc_at, ic_at;
        logic both;
        dc_at = 0; ic_at = 0; both = 1'b0;
        dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 32'h0000_0120;
        ic_req = 1'b1; ic_addr = 32'h0000_0130;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (dc_rdy === 1'b1 && ic_rdy === 1'b1) both = 1'b1;
            if (dc_rdy === 1'b1 && dc_at == 0) begin
                dc_at = c; dc_req = 1'b0;
                total++; if (dc_rdata !== D1) begin bad++; $display("FAIL cont_dc_data got=%h want=%h", dc_rdata, D1); end
            end
            if (ic_rdy === 1'b1 && ic_at == 0) begin
                ic_at = c; ic_req = 1'b0;
                total++; if (ic_rdata !== D2) begin bad++; $display("FAIL cont_ic_data got=%h want=%h", ic_rdata, D2); end
            end
        end
        dc_req = 1'b0; ic_req = 1'b0;
        total++; if (dc_at != 5) begin bad++; $display("FAIL cont_dc_at got=%0d want=5", dc_at); end
        total++; if (ic_at != 11) begin bad++; $display("FAIL cont_ic_at got=%0d want=11", ic_at); end
        total++; if (both !== 1'b0) begin bad++; $display("FAIL cont_both_rdy got=%b want=0", both); end
    endtask

    task automatic test_midop_change();
        int cyc; logic ra;
        do_dc(1'b1, 32'h0000_0210, D2, cyc, ra);
        dc_req = 1'b1; dc_wr = 1'b1; dc_addr = 32'h0000_0200; dc_wdata = D4;
        tick();
        dc_req = 1'b0; dc_addr = 32'h0000_0210; dc_wdata = D5;
        cyc = 1;
        while (dc_rdy !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        total++; if (cyc != 5) begin bad++; $display("FAIL mid_rdy_at got=%0d want=5", cyc); end
        tick();
        do_dc(1'b0, 32'h0000_0200, 128'h0, cyc, ra);
        total++; if (dc_rdata !== D4) begin bad++; $display("FAIL mid_orig_line got=%h want=%h", dc_rdata, D4); end
        do_dc(1'b0, 32'h0000_0210, 128'h0, cyc, ra);
        total++; if (dc_rdata !== D2) begin bad++; $display("FAIL mid_other_line got=%h want=%h", dc_rdata, D2); end
    endtask

    task automatic test_latency1();
        int cyc;
        do_dc1(1'b1, 32'h0000_0080, D5, cyc);
        total++; if (cyc != 2) begin bad++; $display("FAIL lat1_wr_at got=%0d want=2", cyc); end
        do_dc1(1'b1, 32'h0000_0090, D1, cyc);
        do_dc1(1'b0, 32'h0000_0088, 128'h0, cyc);
        total++; if (cyc != 2) begin bad++; $display("FAIL lat1_rd_at got=%0d want=2", cyc); end
        total++; if (dc1_rdata !== D5) begin bad++; $display("FAIL lat1_rd_data got=%h want=%h", dc1_rdata, D5); end
    endtask

    task automatic test_reset_midop();
        int cyc; logic ra; logic seen;
        do_dc(1'b1, 32'h0000_0050, D3, cyc, ra);
        dc_req = 1'b1; dc_wr = 1'b1; dc_addr = 32'h0000_0050; dc_wdata = D4;
        tick();
        tick();
        rsn = 1'b0; dc_req = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || dc_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_state busy=%b rdy=%b want=0,0", busy, dc_rdy); end
        rsn = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (dc_rdy === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_rdy got=%b want=0", seen); end
        do_dc(1'b0, 32'h0000_0050, 128'h0, cyc, ra);
        total++; if (dc_rdata !== D3) begin bad++; $display("FAIL rstmid_contents got=%h want=%h", dc_rdata, D3); end
    endtask

    initial begin
        rsn = 1'b0;
        dc_req = 1'b0; dc_wr = 1'b0; dc_addr = '0; dc_wdata = '0;
        ic_req = 1'b0; ic_addr = '0;
        dc1_req = 1'b0; dc1_wr = 1'b0; dc1_addr = '0; dc1_wdata = '0;
        ic1_req = 1'b0; ic1_addr = '0;
        test_reset();
        test_dc_write_read();
        test_ic_fill();
        test_contention();
        test_midop_change();
        test_latency1();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
